// File: rtl/mips_multicycle_controller.sv
// Multicycle MIPS controller: Moore main FSM plus combinational ALU decoder
// driving the shared-memory datapath, with bne option and illegal detection.
module mips_multicycle_controller #(
   parameter int OP_W    = 6,
   parameter int FUNCT_W = 6,
   parameter bit EN_BNE  = 1'b1
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [OP_W-1:0]    op,
   input  logic [FUNCT_W-1:0] Funct,
   input  logic               Zero,
   output logic               IorD,
   output logic               MemWrite,
   output logic               IRWrite,
   output logic               RegDst,
   output logic               MemtoReg,
   output logic               RegWrite,
   output logic               ALUSrcA,
   output logic [1:0]         ALUSrcB,
   output logic [2:0]         ALU_ctrl,
   output logic [1:0]         PCSrc,
   output logic               PCEn,
   output logic               Illegal,
   output logic [3:0]         state_o
);

   typedef enum logic [3:0] {
      FETCH   = 4'd0,
      DECODE  = 4'd1,
      MEMADR  = 4'd2,
      MEMRD   = 4'd3,
      MEMWB   = 4'd4,
      MEMWR   = 4'd5,
      EXECUTE = 4'd6,
      ALUWB   = 4'd7,
      BRANCH  = 4'd8,
      ADDIEX  = 4'd9,
      ADDIWB  = 4'd10,
      JUMP    = 4'd11
   } state_t;

   localparam logic [OP_W-1:0] OP_RTYPE = OP_W'(6'b000000);
   localparam logic [OP_W-1:0] OP_LW    = OP_W'(6'b100011);
   localparam logic [OP_W-1:0] OP_SW    = OP_W'(6'b101011);
   localparam logic [OP_W-1:0] OP_BEQ   = OP_W'(6'b000100);
   localparam logic [OP_W-1:0] OP_BNE   = OP_W'(6'b000101);
   localparam logic [OP_W-1:0] OP_ADDI  = OP_W'(6'b001000);
   localparam logic [OP_W-1:0] OP_J     = OP_W'(6'b000010);

   state_t state_q, state_d;

   logic       isBne;
   logic       opIllegal;
   logic [2:0] functAlu;
   logic       functIllegal;
   logic       pcWrite, branch, branchNe;
   logic       memWriteS, irWriteS, regWriteS;

   assign isBne = EN_BNE && (op == OP_BNE);

   // Codes 12-15 never appear in normal operation; the default arm recovers them.
   always_comb begin
      state_d   = FETCH;
      opIllegal = 1'b0;
      case (state_q)
         FETCH:   state_d = DECODE;
         DECODE: begin
            if (op == OP_RTYPE)                      state_d = EXECUTE;
            else if (op == OP_LW || op == OP_SW)     state_d = MEMADR;
            else if (op == OP_BEQ || isBne)          state_d = BRANCH;
            else if (op == OP_ADDI)                  state_d = ADDIEX;
            else if (op == OP_J)                     state_d = JUMP;
            else begin
               state_d   = FETCH;
               opIllegal = 1'b1;
            end
         end
         MEMADR:  state_d = (op == OP_LW) ? MEMRD : MEMWR;
         MEMRD:   state_d = MEMWB;
         EXECUTE: state_d = ALUWB;
         ADDIEX:  state_d = ADDIWB;
         default: state_d = FETCH;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) state_q <= FETCH;
      else     state_q <= state_d;
   end

   always_comb begin
      functAlu     = 3'b010;
      functIllegal = 1'b0;
      case (Funct)
         FUNCT_W'(6'b100000): functAlu = 3'b010;
         FUNCT_W'(6'b100010): functAlu = 3'b110;
         FUNCT_W'(6'b100100): functAlu = 3'b000;
         FUNCT_W'(6'b100101): functAlu = 3'b001;
         FUNCT_W'(6'b101010): functAlu = 3'b111;
         default:             functIllegal = 1'b1;
      endcase
   end

   always_comb begin
      IorD      = 1'b0;
      memWriteS = 1'b0;
      irWriteS  = 1'b0;
      RegDst    = 1'b0;
      MemtoReg  = 1'b0;
      regWriteS = 1'b0;
      ALUSrcA   = 1'b0;
      ALUSrcB   = 2'b00;
      ALU_ctrl  = 3'b010;
      PCSrc     = 2'b00;
      pcWrite   = 1'b0;
      branch    = 1'b0;
      branchNe  = 1'b0;
      case (state_q)
         FETCH: begin
            irWriteS = 1'b1;
            ALUSrcB  = 2'b01;
            pcWrite  = 1'b1;
         end
         DECODE:  ALUSrcB = 2'b11;
         MEMADR, ADDIEX: begin
            ALUSrcA = 1'b1;
            ALUSrcB = 2'b10;
         end
         MEMRD:   IorD = 1'b1;
         MEMWR: begin
            IorD      = 1'b1;
            memWriteS = 1'b1;
         end
         MEMWB: begin
            MemtoReg  = 1'b1;
            regWriteS = 1'b1;
         end
         EXECUTE: begin
            ALUSrcA  = 1'b1;
            ALU_ctrl = functAlu;
         end
         ALUWB: begin
            RegDst    = 1'b1;
            regWriteS = 1'b1;
         end
         ADDIWB:  regWriteS = 1'b1;
         BRANCH: begin
            ALUSrcA  = 1'b1;
            ALU_ctrl = 3'b110;
            PCSrc    = 2'b01;
            branch   = (op == OP_BEQ);
            branchNe = isBne;
         end
         JUMP: begin
            PCSrc   = 2'b10;
            pcWrite = 1'b1;
         end
         default: ;
      endcase
   end

   // Write enables are suppressed during reset so an aborted instruction has no side effects.
   assign MemWrite = memWriteS & ~rst;
   assign IRWrite  = irWriteS & ~rst;
   assign RegWrite = regWriteS & ~rst;
   assign PCEn     = (pcWrite | (branch & Zero) | (branchNe & ~Zero)) & ~rst;
   assign Illegal  = (((state_q == DECODE) & opIllegal) |
                      ((state_q == EXECUTE) & functIllegal)) & ~rst;
   assign state_o  = state_q;

endmodule

// File: tb/tb_mips_multicycle_controller.sv
// Directed bench for the multicycle controller; a second instance with bne disabled.
module tb_mips_multicycle_controller;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       rst0 = 1'b1;
   logic [5:0] op = 6'd0;
   logic [5:0] Funct = 6'd0;
   logic       Zero = 1'b0;

   logic       IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA, PCEn, Illegal;
   logic [1:0] ALUSrcB, PCSrc;
   logic [2:0] ALU_ctrl;
   logic [3:0] state_o;

   logic       IorD0, MemWrite0, IRWrite0, RegDst0, MemtoReg0, RegWrite0, ALUSrcA0, PCEn0, Illegal0;
   logic [1:0] ALUSrcB0, PCSrc0;
   logic [2:0] ALU_ctrl0;
   logic [3:0] state0;

   int vectors = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   mips_multicycle_controller #(.OP_W(6), .FUNCT_W(6), .EN_BNE(1'b1)) dut (
      .clk(clk), .rst(rst), .op(op), .Funct(Funct), .Zero(Zero),
      .IorD(IorD), .MemWrite(MemWrite), .IRWrite(IRWrite), .RegDst(RegDst),
      .MemtoReg(MemtoReg), .RegWrite(RegWrite), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
      .ALU_ctrl(ALU_ctrl), .PCSrc(PCSrc), .PCEn(PCEn), .Illegal(Illegal), .state_o(state_o)
   );

   mips_multicycle_controller #(.OP_W(6), .FUNCT_W(6), .EN_BNE(1'b0)) dut0 (
      .clk(clk), .rst(rst0), .op(op), .Funct(Funct), .Zero(Zero),
      .IorD(IorD0), .MemWrite(MemWrite0), .IRWrite(IRWrite0), .RegDst(RegDst0),
      .MemtoReg(MemtoReg0), .RegWrite(RegWrite0), .ALUSrcA(ALUSrcA0), .ALUSrcB(ALUSrcB0),
      .ALU_ctrl(ALU_ctrl0), .PCSrc(PCSrc0), .PCEn(PCEn0), .Illegal(Illegal0), .state_o(state0)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      for (int i = 0; i < 2; i++) begin
         step();
         vectors++;
         if (state_o !== 4'd0 || IRWrite !== 1'b0 || PCEn !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL reset_hold: state=%0d IRWrite=%b PCEn=%b, expected 0/0/0", state_o, IRWrite, PCEn);
         end
      end
      rst = 1'b0;
      #1;
      vectors++;
      if (IRWrite !== 1'b1 || PCEn !== 1'b1 || ALUSrcB !== 2'b01 || state_o !== 4'd0) begin
         miscompares++;
         $display("[TB] FAIL first_fetch: state=%0d IRWrite=%b PCEn=%b ALUSrcB=%b, expected 0/1/1/01",
                  state_o, IRWrite, PCEn, ALUSrcB);
      end
   endtask

   task automatic test_rtype();
      logic [5:0] functTab[5] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
      logic [2:0] aluTab[5]   = '{3'b010, 3'b110, 3'b000, 3'b001, 3'b111};
      int seq[5] = '{0, 1, 6, 7, 0};
      for (int f = 0; f < 5; f++) begin
         op = 6'b000000;
         Funct = functTab[f];
         #1;
         for (int i = 0; i < 5; i++) begin
            vectors++;
            if (state_o !== 4'(seq[i])) begin
               miscompares++;
               $display("[TB] FAIL rtype_state funct=%b step %0d: got %0d, expected %0d", Funct, i, state_o, seq[i]);
            end
            if (seq[i] == 6) begin
               vectors++;
               if (ALU_ctrl !== aluTab[f] || ALUSrcA !== 1'b1 || ALUSrcB !== 2'b00 || Illegal !== 1'b0) begin
                  miscompares++;
                  $display("[TB] FAIL rtype_exec funct=%b: ALU_ctrl=%b ALUSrcA=%b ALUSrcB=%b Illegal=%b, expected %b/1/00/0",
                           Funct, ALU_ctrl, ALUSrcA, ALUSrcB, Illegal, aluTab[f]);
               end
            end
            if (seq[i] == 7) begin
               vectors++;
               if (RegWrite !== 1'b1 || RegDst !== 1'b1 || MemtoReg !== 1'b0) begin
                  miscompares++;
                  $display("[TB] FAIL rtype_wb: RegWrite=%b RegDst=%b MemtoReg=%b, expected 1/1/0", RegWrite, RegDst, MemtoReg);
               end
            end
            if (i < 4) step();
         end
      end
   endtask

   task automatic test_lw_sw();
      int seqLw[6] = '{0, 1, 2, 3, 4, 0};
      int seqSw[5] = '{0, 1, 2, 5, 0};
      op = 6'b100011;
      #1;
      for (int i = 0; i < 6; i++) begin
         vectors++;
         if (state_o !== 4'(seqLw[i]) || MemWrite !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL lw_state step %0d: state=%0d MemWrite=%b, expected %0d/0", i, state_o, MemWrite, seqLw[i]);
         end
         if (seqLw[i] == 2) begin
            vectors++;
            if (ALUSrcA !== 1'b1 || ALUSrcB !== 2'b10 || ALU_ctrl !== 3'b010) begin
               miscompares++;
               $display("[TB] FAIL lw_memadr: ALUSrcA=%b ALUSrcB=%b ALU_ctrl=%b, expected 1/10/010", ALUSrcA, ALUSrcB, ALU_ctrl);
            end
         end
         if (seqLw[i] == 3) begin
            vectors++;
            if (IorD !== 1'b1 || RegWrite !== 1'b0) begin
               miscompares++;
               $display("[TB] FAIL lw_memrd: IorD=%b RegWrite=%b, expected 1/0", IorD, RegWrite);
            end
         end
         if (seqLw[i] == 4) begin
            vectors++;
            if (MemtoReg !== 1'b1 || RegWrite !== 1'b1 || RegDst !== 1'b0) begin
               miscompares++;
               $display("[TB] FAIL lw_memwb: MemtoReg=%b RegWrite=%b RegDst=%b, expected 1/1/0", MemtoReg, RegWrite, RegDst);
            end
         end
         if (i < 5) step();
      end
      op = 6'b101011;
      #1;
      for (int i = 0; i < 5; i++) begin
         vectors++;
         if (state_o !== 4'(seqSw[i]) || MemWrite !== (seqSw[i] == 5)) begin
            miscompares++;
            $display("[TB] FAIL sw_state step %0d: state=%0d MemWrite=%b, expected %0d/%b",
                     i, state_o, MemWrite, seqSw[i], seqSw[i] == 5);
         end
         if (seqSw[i] == 5) begin
            vectors++;
            if (IorD !== 1'b1 || RegWrite !== 1'b0) begin
               miscompares++;
               $display("[TB] FAIL sw_memwr: IorD=%b RegWrite=%b, expected 1/0", IorD, RegWrite);
            end
         end
         if (i < 4) step();
      end
   endtask

   task automatic test_branch();
      logic [5:0] opTab[4]  = '{6'b000100, 6'b000100, 6'b000101, 6'b000101};
      logic       zTab[4]   = '{1'b1, 1'b0, 1'b1, 1'b0};
      logic       enTab[4]  = '{1'b1, 1'b0, 1'b0, 1'b1};
      int seq[4] = '{0, 1, 8, 0};
      for (int b = 0; b < 4; b++) begin
         op = opTab[b];
         Zero = zTab[b];
         #1;
         for (int i = 0; i < 4; i++) begin
            vectors++;
            if (state_o !== 4'(seq[i])) begin
               miscompares++;
               $display("[TB] FAIL branch_state op=%b step %0d: got %0d, expected %0d", op, i, state_o, seq[i]);
            end
            if (seq[i] == 1) begin
               vectors++;
               if (Illegal !== 1'b0 || ALUSrcB !== 2'b11) begin
                  miscompares++;
                  $display("[TB] FAIL branch_decode op=%b: Illegal=%b ALUSrcB=%b, expected 0/11", op, Illegal, ALUSrcB);
               end
            end
            if (seq[i] == 8) begin
               vectors++;
               if (PCEn !== enTab[b] || PCSrc !== 2'b01 || ALU_ctrl !== 3'b110 || ALUSrcA !== 1'b1) begin
                  miscompares++;
                  $display("[TB] FAIL branch_exec op=%b Zero=%b: PCEn=%b PCSrc=%b ALU_ctrl=%b ALUSrcA=%b, expected %b/01/110/1",
                           op, Zero, PCEn, PCSrc, ALU_ctrl, ALUSrcA, enTab[b]);
               end
            end
            if (i < 3) step();
         end
      end
      Zero = 1'b0;
   endtask

   task automatic test_bne_disabled();
      op = 6'b000101;
      rst0 = 1'b0;
      #1;
      vectors++;
      if (state0 !== 4'd0 || Illegal0 !== 1'b0) begin
         miscompares++;
         $display("[TB] FAIL bne_off_fetch: state=%0d Illegal=%b, expected 0/0", state0, Illegal0);
      end
      step();
      vectors++;
      if (state0 !== 4'd1 || Illegal0 !== 1'b1) begin
         miscompares++;
         $display("[TB] FAIL bne_off_decode: state=%0d Illegal=%b, expected 1/1", state0, Illegal0);
      end
      step();
      vectors++;
      if (state0 !== 4'd0 || Illegal0 !== 1'b0) begin
         miscompares++;
         $display("[TB] FAIL bne_off_return: state=%0d Illegal=%b, expected 0/0", state0, Illegal0);
      end
      rst0 = 1'b1;
      step();
   endtask

   task automatic test_jump_illegal();
      int seqJ[4] = '{0, 1, 11, 0};
      op = 6'b000010;
      #1;
      for (int i = 0; i < 4; i++) begin
         vectors++;
         if (state_o !== 4'(seqJ[i])) begin
            miscompares++;
            $display("[TB] FAIL jump_state step %0d: got %0d, expected %0d", i, state_o, seqJ[i]);
         end
         if (seqJ[i] == 11) begin
            vectors++;
            if (PCSrc !== 2'b10 || PCEn !== 1'b1 || IRWrite !== 1'b0) begin
               miscompares++;
               $display("[TB] FAIL jump_exec: PCSrc=%b PCEn=%b IRWrite=%b, expected 10/1/0", PCSrc, PCEn, IRWrite);
            end
         end
         if (i < 3) step();
      end
      op = 6'b111111;
      #1;
      vectors++;
      if (Illegal !== 1'b0 || state_o !== 4'd0) begin
         miscompares++;
         $display("[TB] FAIL illegal_pre: state=%0d Illegal=%b, expected 0/0", state_o, Illegal);
      end
      step();
      vectors++;
      if (Illegal !== 1'b1 || state_o !== 4'd1) begin
         miscompares++;
         $display("[TB] FAIL illegal_pulse: state=%0d Illegal=%b, expected 1/1", state_o, Illegal);
      end
      step();
      vectors++;
      if (Illegal !== 1'b0 || state_o !== 4'd0) begin
         miscompares++;
         $display("[TB] FAIL illegal_return: state=%0d Illegal=%b, expected 0/0", state_o, Illegal);
      end
      op = 6'b000000;
      Funct = 6'b111111;
      step();
      step();
      vectors++;
      if (state_o !== 4'd6 || Illegal !== 1'b1 || ALU_ctrl !== 3'b010) begin
         miscompares++;
         $display("[TB] FAIL bad_funct_exec: state=%0d Illegal=%b ALU_ctrl=%b, expected 6/1/010", state_o, Illegal, ALU_ctrl);
      end
      step();
      vectors++;
      if (state_o !== 4'd7 || Illegal !== 1'b0 || RegWrite !== 1'b1) begin
         miscompares++;
         $display("[TB] FAIL bad_funct_wb: state=%0d Illegal=%b RegWrite=%b, expected 7/0/1", state_o, Illegal, RegWrite);
      end
      step();
   endtask

   task automatic test_back_to_back();
      logic [5:0] opTab[2] = '{6'b001000, 6'b000010};
      int seq[2][5] = '{'{0, 1, 9, 10, 0}, '{0, 1, 11, 0, 0}};
      int len[2] = '{4, 3};
      for (int k = 0; k < 2; k++) begin
         op = opTab[k];
         #1;
         for (int i = 0; i <= len[k]; i++) begin
            vectors++;
            if (state_o !== 4'(seq[k][i])) begin
               miscompares++;
               $display("[TB] FAIL b2b_state op=%b step %0d: got %0d, expected %0d", op, i, state_o, seq[k][i]);
            end
            if (seq[k][i] == 9) begin
               vectors++;
               if (ALUSrcA !== 1'b1 || ALUSrcB !== 2'b10 || RegWrite !== 1'b0) begin
                  miscompares++;
                  $display("[TB] FAIL addi_ex: ALUSrcA=%b ALUSrcB=%b RegWrite=%b, expected 1/10/0", ALUSrcA, ALUSrcB, RegWrite);
               end
            end
            if (seq[k][i] == 10) begin
               vectors++;
               if (RegWrite !== 1'b1 || RegDst !== 1'b0 || MemtoReg !== 1'b0) begin
                  miscompares++;
                  $display("[TB] FAIL addi_wb: RegWrite=%b RegDst=%b MemtoReg=%b, expected 1/0/0", RegWrite, RegDst, MemtoReg);
               end
            end
            if (i < len[k]) step();
         end
      end
   endtask

   task automatic test_reset_abort();
      op = 6'b101011;
      #1;
      step();
      step();
      step();
      vectors++;
      if (state_o !== 4'd5 || MemWrite !== 1'b1) begin
         miscompares++;
         $display("[TB] FAIL abort_pre: state=%0d MemWrite=%b, expected 5/1", state_o, MemWrite);
      end
      rst = 1'b1;
      #1;
      vectors++;
      if (MemWrite !== 1'b0 || RegWrite !== 1'b0 || PCEn !== 1'b0 || IRWrite !== 1'b0) begin
         miscompares++;
         $display("[TB] FAIL abort_gate: MemWrite=%b RegWrite=%b PCEn=%b IRWrite=%b, expected 0/0/0/0",
                  MemWrite, RegWrite, PCEn, IRWrite);
      end
      step();
      vectors++;
      if (state_o !== 4'd0) begin
         miscompares++;
         $display("[TB] FAIL abort_state: got %0d, expected 0", state_o);
      end
      rst = 1'b0;
      #1;
      vectors++;
      if (IRWrite !== 1'b1 || PCEn !== 1'b1) begin
         miscompares++;
         $display("[TB] FAIL abort_refetch: IRWrite=%b PCEn=%b, expected 1/1", IRWrite, PCEn);
      end
   endtask

   initial begin
      test_reset();
      test_rtype();
      test_lw_sw();
      test_branch();
      test_bne_disabled();
      test_jump_illegal();
      test_back_to_back();
      test_reset_abort();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
